// File: rtl/timer_scheduler_pkg.sv
// Shared definitions for the timer scheduler: FSM state encoding and the
// per-requester multiplier field width.
package timer_scheduler_pkg;

    localparam int MULT_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/timer_scheduler_if.sv
// Requester-facing bundle of the timer scheduler. The master side drives
// req/mult; the slave (scheduler) side drives grant/done/busy/owner and a state view.
interface timer_scheduler_if #(
    parameter int NREQ = 4
) ();
    import timer_scheduler_pkg::*;

    // req is a level: a requester raises it and holds it until its done pulse
    // is seen; dropping it while granted cancels the delay.
    logic [NREQ-1:0]        req;
    logic [MULT_W*NREQ-1:0] mult;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        done;
    logic                   busy;
    logic [2:0]             owner;
    state_e                 state;

    modport master (
        output req, mult,
        input  grant, done, busy, owner, state
    );

    modport slave (
        input  req, mult,
        output grant, done, busy, owner, state
    );

endinterface

// File: rtl/timer_scheduler_delay_timer.sv
// Retriggerable delay timer: a start pulse loads the target and restarts the
// count at 1; expired is high while the count equals the target.
module delay_timer #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cancel,
    input  logic [CW-1:0] target,
    output logic          expired
);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] target_q, target_d;
    logic          running_q, running_d;

    assign expired = running_q && (count_q == target_q);

    always_comb begin
        count_d   = count_q;
        target_d  = target_q;
        running_d = running_q;
        if (cancel) begin
            count_d   = '0;
            running_d = 1'b0;
        end else if (start) begin
            target_d  = target;
            count_d   = CW'(1);
            running_d = 1'b1;
        end else if (running_q) begin
            // Stop counting once the target is hit so the flag lasts one cycle.
            if (expired) begin
                running_d = 1'b0;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            target_q  <= '0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            target_q  <= target_d;
            running_q <= running_d;
        end
    end

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin arbiter that lends one delay timer to NREQ requesters, each asking
// for TVALUE<<mult cycles, and pulses the owner's done line when it elapses.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int TVALUE = 7,
    parameter int CW     = 32
) (
    input  logic                clk,
    input  logic                reset,
    timer_scheduler_if.slave    bus
);

    state_e        state_q, state_d;
    logic [2:0]    owner_q, owner_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic          busy_q, busy_d;

    logic          start;
    logic          cancel;
    logic          expired;
    logic [CW-1:0] target_new;

    logic [7:0]    req_pad;
    logic [15:0]   mult_pad;
    logic [7:0]    owner_oh;
    logic          found;
    logic [2:0]    win;
    logic [3:0]    idx;
    logic [MULT_W-1:0] win_mult;

    // Zero-padded copies let the 3-bit indices address any legal NREQ.
    assign req_pad  = 8'(bus.req);
    assign mult_pad = 16'(bus.mult);

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = {1'b0, ptr_q} + 4'(off);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!found && req_pad[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end

    assign win_mult   = mult_pad[{win, 1'b0} +: MULT_W];
    assign target_new = CW'(TVALUE) << win_mult;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        start   = 1'b0;
        cancel  = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    owner_d = win;
                    ptr_d   = win;
                    start   = 1'b1;
                end
            end
            RUN: begin
                // A dropped request wins over a simultaneous expiry: no done.
                if (!req_pad[owner_q]) begin
                    state_d = IDLE;
                    cancel  = 1'b1;
                end else if (expired) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        owner_oh = 8'b1 << owner_d;
        grant_d  = '0;
        done_d   = '0;
        if (state_d == RUN) begin
            grant_d = owner_oh[NREQ-1:0];
        end
        if (state_d == DONE) begin
            done_d = owner_oh[NREQ-1:0];
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= 3'(NREQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    delay_timer #(
        .CW (CW)
    ) u_delay_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .cancel  (cancel),
        .target  (target_new),
        .expired (expired)
    );

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: single request, multiplier scaling,
// simultaneous requests, round-robin fairness, cancel and asynchronous reset.
module tb_timer_scheduler;
  import timer_scheduler_pkg::*;

  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  timer_scheduler_if #(.NREQ(NREQ)) bus ();

  timer_scheduler #(
    .NREQ   (NREQ),
    .TVALUE (7),
    .CW     (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge; outputs are stable there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg, input logic [3:0] ed,
                     input logic eb, input logic [2:0] eo);
    vectors++;
    assert (bus.grant === eg) else begin
      miscompares++;
      $error("FAIL %s grant got %b exp %b", tag, bus.grant, eg);
    end
    assert (bus.done === ed) else begin
      miscompares++;
      $error("FAIL %s done got %b exp %b", tag, bus.done, ed);
    end
    assert (bus.busy === eb) else begin
      miscompares++;
      $error("FAIL %s busy got %b exp %b", tag, bus.busy, eb);
    end
    assert (bus.owner === eo) else begin
      miscompares++;
      $error("FAIL %s owner got %0d exp %0d", tag, bus.owner, eo);
    end
  endtask

  // len grant cycles for requester o followed by its done cycle.
  task automatic serve(input string tag, input int o, input int len);
    logic [3:0] oh;
    oh = 4'b0001 << o;
    for (int k = 0; k < len; k++) begin
      step();
      chk(tag, oh, 4'b0000, 1'b1, 3'(o));
    end
    step();
    chk({tag, "_done"}, 4'b0000, oh, 1'b1, 3'(o));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    bus.req  = '0;
    bus.mult = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 4'b0000, 4'b0000, 1'b0, 3'd0);
    vectors++;
    assert (bus.state === IDLE) else begin
      miscompares++;
      $error("FAIL reset_state got %0d exp %0d", bus.state, IDLE);
    end
    reset = 1'b1;
    step();
    chk("idle", 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Single request, target 7: grant 1..7, done 8, idle 9.
    bus.req = 4'b0001;
    serve("single", 0, 7);
    bus.req = 4'b0000;
    step();
    chk("single_idle", 4'b0000, 4'b0000, 1'b0, 3'd0);

    // mult0=3 -> 56 cycles; a later change of mult is ignored.
    bus.mult = 8'b0000_0011;
    bus.req  = 4'b0001;
    step();
    chk("mult_c1", 4'b0001, 4'b0000, 1'b1, 3'd0);
    bus.mult = 8'b0000_0000;
    serve("mult", 0, 55);
    bus.req = 4'b0000;
    step();
    chk("mult_idle", 4'b0000, 4'b0000, 1'b0, 3'd0);

    // Simultaneous req0/req2 after reset: 0 first, then 2 granted from cycle 10.
    do_reset();
    bus.req = 4'b0101;
    serve("simul0", 0, 7);
    bus.req = 4'b0100;
    step();
    chk("simul_gap", 4'b0000, 4'b0000, 1'b0, 3'd0);
    serve("simul2", 2, 7);
    bus.req = 4'b0000;
    step();
    chk("simul_idle", 4'b0000, 4'b0000, 1'b0, 3'd2);

    // Fairness: all requests held, order 0,1,2,3,0 with dones 9 cycles apart.
    do_reset();
    bus.req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      serve("fair", r % 4, 7);
      if (r == 4) bus.req = 4'b0000;
      step();
      chk("fair_gap", 4'b0000, 4'b0000, 1'b0, 3'(r % 4));
    end

    // Cancel: req1 dropped in cycle 4, then pending req3 is served.
    bus.req = 4'b1010;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("cancel_run", 4'b0010, 4'b0000, 1'b1, 3'd1);
    end
    bus.req = 4'b1000;
    step();
    chk("cancel_idle", 4'b0000, 4'b0000, 1'b0, 3'd1);
    serve("cancel3", 3, 7);
    bus.req = 4'b0000;
    step();
    chk("cancel3_idle", 4'b0000, 4'b0000, 1'b0, 3'd3);

    // Reset mid-RUN of requester 1; afterwards requester 0 beats requester 2.
    bus.req = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("rst_run", 4'b0010, 4'b0000, 1'b1, 3'd1);
    end
    reset = 1'b0;
    #1;
    chk("rst_async", 4'b0000, 4'b0000, 1'b0, 3'd0);
    step();
    chk("rst_hold", 4'b0000, 4'b0000, 1'b0, 3'd0);
    reset   = 1'b1;
    bus.req = 4'b0101;
    step();
    chk("rst_prio", 4'b0001, 4'b0000, 1'b1, 3'd0);
    serve("rst_serve", 0, 6);
    bus.req = 4'b0000;
    step();
    chk("rst_idle", 4'b0000, 4'b0000, 1'b0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
